dmem_arbiter: RTL and testbench



---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_arbiter_rr_pick2.sv | 32 +++
 rtl/dmem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter.
// Exports ADDR_W, DATA_W, arb_state_t and port_id_t.
package dmem_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  typedef logic port_id_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin select.
// Ports: req[1:0], prio in; one-hot gnt[1:0] and winner id out.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   prio,
  output logic [1:0] gnt,
  output port_id_t   id
);

  always_comb begin
    gnt = 2'b00;
    id  = prio;
    unique case (req)
      2'b01: begin
        gnt = 2'b01;
        id  = 1'b0;
      end
      2'b10: begin
        gnt = 2'b10;
        id  = 1'b1;
      end
      2'b11: begin
        gnt[prio] = 1'b1;
        id        = prio;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of dmem.
// Ports: clk, reset (sync, active-high); per port pX_req/we/addr/wd
// in, pX_gnt (comb), pX_rvalid/pX_rd (registered) out; dmem
// mw/addr/wd out, rd in. DMEM_ARB_LOCK_EN adds p0_lock/p1_lock
// and a bounded lock state machine.
module dmem_arbiter #(
  parameter int ADDR_W   = dmem_arb_pkg::ADDR_W,
  parameter int DATA_W   = dmem_arb_pkg::DATA_W,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wd,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rd,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wd,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rd,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              p0_lock,
  input  logic              p1_lock,
`endif
  output logic              mw,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wd,
  input  logic [DATA_W-1:0] rd
);

  import dmem_arb_pkg::*;

  port_id_t   prio;
  port_id_t   id;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       rd0;
  logic       rd1;

`ifdef DMEM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             exit;

  // While locked, only the lock owner may compete.
  always_comb begin
    req = {p1_req, p0_req};
    unique case (state)
      LOCK0:   req[1] = 1'b0;
      LOCK1:   req[0] = 1'b0;
      default: ;
    endcase
    if (reset) req = 2'b00;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    exit      = 1'b0;
    unique case (state)
      LOCK0: begin
        if (gnt[0]) cnt_nxt = cnt + 1'b1;
        if (!p0_lock ||
            (gnt[0] && cnt_nxt == CNT_W'(MAX_LOCK))) begin
          state_nxt = ARB;
          exit      = 1'b1;
        end
      end
      LOCK1: begin
        if (gnt[1]) cnt_nxt = cnt + 1'b1;
        if (!p1_lock ||
            (gnt[1] && cnt_nxt == CNT_W'(MAX_LOCK))) begin
          state_nxt = ARB;
          exit      = 1'b1;
        end
      end
      default: begin
        // A single-grant cap means a lock could never extend.
        if (MAX_LOCK > 1) begin
          if (gnt[0] && p0_lock) begin
            state_nxt = LOCK0;
            cnt_nxt   = CNT_W'(1);
          end else if (gnt[1] && p1_lock) begin
            state_nxt = LOCK1;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end
`else
  assign req = reset ? 2'b00 : {p1_req, p0_req};
`endif

  rr_pick2 u_pick (
    .req  (req),
    .prio (prio),
    .gnt  (gnt),
    .id   (id)
  );

  assign p0_gnt = gnt[0];
  assign p1_gnt = gnt[1];

  always_comb begin
    mw   = 1'b0;
    addr = '0;
    wd   = '0;
    unique case (1'b1)
      gnt[0]: begin
        mw   = p0_we;
        addr = p0_addr;
        wd   = p0_wd;
      end
      gnt[1]: begin
        mw   = p1_we;
        addr = p1_addr;
        wd   = p1_wd;
      end
      default: ;
    endcase
  end

  assign rd0 = gnt[0] & ~p0_we;
  assign rd1 = gnt[1] & ~p1_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (|gnt) begin
      prio <= ~id;
`ifdef DMEM_ARB_LOCK_EN
    end else if (exit) begin
      // Lock released without a grant: hand turn to the other port.
      prio <= (state == LOCK0) ? 1'b1 : 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rd     <= '0;
      p1_rd     <= '0;
    end else begin
      p0_rvalid <= rd0;
      p1_rvalid <= rd1;
      if (rd0) p0_rd <= rd;
      if (rd1) p1_rd <= rd;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a small dmem model.
// Stimulus queues expected per-cycle outputs; a monitor checks them.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p0_wd, p1_addr, p1_wd;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [15:0] p0_rd, p1_rd;
  logic        p0_lock, p1_lock;
  logic        mw;
  logic [15:0] addr, wd, rd;

  logic [15:0] mem [32];

  typedef struct packed {
    logic        g0;
    logic        g1;
    logic        mw;
    logic [15:0] a;
    logic [15:0] d;
    logic        v0;
    logic [15:0] r0;
    logic        v1;
    logic [15:0] r1;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wd     (p0_wd),
    .p0_gnt    (p0_gnt),
    .p0_rvalid (p0_rvalid),
    .p0_rd     (p0_rd),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wd     (p1_wd),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .p1_rd     (p1_rd),
`ifdef DMEM_ARB_LOCK_EN
    .p0_lock   (p0_lock),
    .p1_lock   (p1_lock),
`endif
    .mw        (mw),
    .addr      (addr),
    .wd        (wd),
    .rd        (rd)
  );

  // dmem model: preloaded during reset, combinational read.
  always @(posedge clk) begin
    if (reset) begin
      mem[2]  <= 16'h1111;
      mem[4]  <= 16'h2222;
      mem[14] <= 16'h0000;
    end
    if (mw) mem[addr[4:0]] <= wd;
  end
  assign rd = mem[addr[4:0]];

  task automatic chk(input string n, input logic [47:0] act,
                     input logic [47:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("gnt", {46'd0, p1_gnt, p0_gnt}, {46'd0, e.g1, e.g0});
      chk("mem", {15'd0, mw, addr, wd}, {15'd0, e.mw, e.a, e.d});
      chk("p0_ret", {31'd0, p0_rvalid, p0_rd},
          {31'd0, e.v0, e.r0});
      chk("p1_ret", {31'd0, p1_rvalid, p1_rd},
          {31'd0, e.v1, e.r1});
    end
  end

  task automatic step(
    input logic rst,
    input logic r0, input logic w0, input logic [15:0] a0,
    input logic [15:0] d0,
    input logic r1, input logic w1, input logic [15:0] a1,
    input logic [15:0] d1,
    input exp_t e
  );
    reset   = rst;
    p0_req  = r0;
    p0_we   = w0;
    p0_addr = a0;
    p0_wd   = d0;
    p1_req  = r1;
    p1_we   = w1;
    p1_addr = a1;
    p1_wd   = d1;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t ex(
    input logic g0, input logic g1, input logic m,
    input logic [15:0] a, input logic [15:0] d,
    input logic v0, input logic [15:0] r0,
    input logic v1, input logic [15:0] r1
  );
    exp_t e;
    e = '{g0, g1, m, a, d, v0, r0, v1, r1};
    return e;
  endfunction

  initial begin
    reset   = 1'b1;
    p0_req  = 1'b0;
    p0_we   = 1'b0;
    p0_addr = '0;
    p0_wd   = '0;
    p1_req  = 1'b0;
    p1_we   = 1'b0;
    p1_addr = '0;
    p1_wd   = '0;
    p0_lock = 1'b0;
    p1_lock = 1'b0;
    @(posedge clk);
    #1;
    // reset held with a p0 write pending
    for (int i = 0; i < 3; i++)
      step(1, 1,1,16'h000E,16'h000E, 0,0,0,0,
           ex(0,0,0,0,0, 0,0, 0,0));
    // p0 write then read back
    step(0, 1,1,16'h000E,16'h000E, 0,0,0,0,
         ex(1,0,1,16'h000E,16'h000E, 0,0, 0,0));
    step(0, 1,0,16'h000E,0, 0,0,0,0,
         ex(1,0,0,16'h000E,0, 0,0, 0,0));
    // p1 alone, turn passes back to p0
    step(0, 0,0,0,0, 1,0,16'h0004,0,
         ex(0,1,0,16'h0004,0, 1,16'h000E, 0,0));
    // both requesting: strict alternation
    step(0, 1,0,16'h0002,0, 1,0,16'h0004,0,
         ex(1,0,0,16'h0002,0, 0,16'h000E, 1,16'h2222));
    for (int i = 0; i < 2; i++) begin
      step(0, 1,0,16'h0002,0, 1,0,16'h0004,0,
           ex(0,1,0,16'h0004,0, 1,16'h1111, 0,16'h2222));
      step(0, 1,0,16'h0002,0, 1,0,16'h0004,0,
           ex(1,0,0,16'h0002,0, 0,16'h1111, 1,16'h2222));
    end
    step(0, 1,0,16'h0002,0, 1,0,16'h0004,0,
         ex(0,1,0,16'h0004,0, 1,16'h1111, 0,16'h2222));
    // same-cycle write by p0 and read by p1 of 0010
    step(0, 1,1,16'h0010,16'hABCD, 1,0,16'h0010,0,
         ex(1,0,1,16'h0010,16'hABCD, 0,16'h1111, 1,16'h2222));
    step(0, 0,0,0,0, 1,0,16'h0010,0,
         ex(0,1,0,16'h0010,0, 0,16'h1111, 0,16'h2222));
    // p1 drops its request before being granted
    step(0, 1,0,16'h000E,0, 1,0,16'h0004,0,
         ex(1,0,0,16'h000E,0, 0,16'h1111, 1,16'hABCD));
    step(0, 1,0,16'h0002,0, 0,0,0,0,
         ex(1,0,0,16'h0002,0, 1,16'h000E, 0,16'hABCD));
    step(0, 1,0,16'h000E,0, 1,0,16'h0004,0,
         ex(0,1,0,16'h0004,0, 1,16'h1111, 0,16'hABCD));
    // idle cycles keep prio
    step(0, 0,0,0,0, 0,0,0,0,
         ex(0,0,0,0,0, 0,16'h1111, 1,16'h2222));
    step(0, 0,0,0,0, 0,0,0,0,
         ex(0,0,0,0,0, 0,16'h1111, 0,16'h2222));
    step(0, 1,0,16'h000E,0, 1,0,16'h0004,0,
         ex(1,0,0,16'h000E,0, 0,16'h1111, 0,16'h2222));
    step(0, 0,0,0,0, 0,0,0,0,
         ex(0,0,0,0,0, 1,16'h000E, 0,16'h2222));
    // reset mid-operation: pending rvalid cleared, write dropped
    step(0, 1,0,16'h0002,0, 0,0,0,0,
         ex(1,0,0,16'h0002,0, 0,16'h000E, 0,16'h2222));
    step(1, 0,0,0,0, 1,1,16'h0010,16'h5555,
         ex(0,0,0,0,0, 1,16'h1111, 0,16'h2222));
    step(0, 0,0,0,0, 0,0,0,0,
         ex(0,0,0,0,0, 0,0, 0,0));
    step(0, 0,0,0,0, 1,0,16'h0010,0,
         ex(0,1,0,16'h0010,0, 0,0, 0,0));
    step(0, 0,0,0,0, 0,0,0,0,
         ex(0,0,0,0,0, 0,0, 1,16'hABCD));
`ifdef DMEM_ARB_LOCK_EN
    // p1 locks: 8 consecutive p1 grants, then p0
    p1_lock = 1'b1;
    step(0, 1,0,16'h0002,0, 1,0,16'h0004,0,
         ex(1,0,0,16'h0002,0, 0,0, 0,16'hABCD));
    step(0, 1,0,16'h0002,0, 1,0,16'h0004,0,
         ex(0,1,0,16'h0004,0, 1,16'h1111, 0,16'hABCD));
    for (int i = 0; i < 7; i++)
      step(0, 1,0,16'h0002,0, 1,0,16'h0004,0,
           ex(0,1,0,16'h0004,0, 0,16'h1111, 1,16'h2222));
    step(0, 1,0,16'h0002,0, 1,0,16'h0004,0,
         ex(1,0,0,16'h0002,0, 0,16'h1111, 1,16'h2222));
    p1_lock = 1'b0;
    step(0, 0,0,0,0, 0,0,0,0,
         ex(0,0,0,0,0, 1,16'h1111, 0,16'h2222));
`endif
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
